// File: rtl/stopwatch_ctrl_if.sv
// Button/time inputs and run/clear/display/LED outputs between the stopwatch
// controller and its neighbours (btn_xd, timer, seg_drive).
interface stopwatch_ctrl_if;
  logic        i_start;
  logic        i_select;
  logic        i_page;
  logic [23:0] i_time;
  logic        o_run;
  logic        o_clear;
  logic [15:0] o_data;
  logic [2:0]  o_led;

  modport master (
    output i_start, i_select, i_page, i_time,
    input  o_run, o_clear, o_data, o_led
  );

  modport slave (
    input  i_start, i_select, i_page, i_time,
    output o_run, o_clear, o_data, o_led
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/pause/lap/clear FSM, lap capture, display page
// selection and status LEDs (LED0 blinks while paused).
module stopwatch_ctrl #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(BLINK_DIV);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] LAP   = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic             armed;
  logic             start_p1, select_p1, page_p1;
  logic             start_ev, select_ev, page_ev;
  logic [23:0]      lap_reg;
  logic             page;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink;
  logic [23:0]      src;
  logic             led0;

  // The first edge after reset only loads the history registers, so a button
  // held through reset is seen as already pressed and never fires.
  assign start_ev  = armed & bus.i_start & ~start_p1;
  assign select_ev = armed & bus.i_select & ~select_p1 & ~start_ev;
  assign page_ev   = armed & bus.i_page & ~page_p1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ev) state_nxt = RUN;
      RUN:     if (start_ev) state_nxt = PAUSE;
               else if (select_ev) state_nxt = LAP;
      LAP:     if (start_ev) state_nxt = PAUSE;
               else if (select_ev) state_nxt = RUN;
      PAUSE:   if (start_ev) state_nxt = RUN;
               else if (select_ev) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: button history
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      armed     <= 1'b0;
      start_p1  <= 1'b0;
      select_p1 <= 1'b0;
      page_p1   <= 1'b0;
    end else begin
      armed     <= 1'b1;
      start_p1  <= bus.i_start;
      select_p1 <= bus.i_select;
      page_p1   <= bus.i_page;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      bus.o_run   <= 1'b0;
      bus.o_clear <= 1'b0;
      lap_reg     <= 24'h000000;
    end else begin
      state       <= state_nxt;
      bus.o_run   <= (state_nxt == RUN) || (state_nxt == LAP);
      bus.o_clear <= (state == PAUSE) && select_ev;
      if ((state == RUN) && select_ev)
        lap_reg <= bus.i_time;
      else if ((state == PAUSE) && select_ev)
        lap_reg <= 24'h000000;
    end
  end

  assign src = (state == LAP) ? lap_reg : bus.i_time;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      page       <= 1'b0;
      bus.o_data <= 16'h0000;
    end else begin
      page       <= page ^ page_ev;
      bus.o_data <= page ? src[23:8] : src[15:0];
    end
  end

  // Blink phase restarts high on every entry to PAUSE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (state_nxt == PAUSE) begin
      if (state != PAUSE) begin
        blink_cnt <= '0;
        blink     <= 1'b1;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end else begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end
  end

  always_comb begin
    led0 = 1'b0;
    case (state)
      RUN, LAP: led0 = 1'b1;
      PAUSE:    led0 = blink;
      default:  led0 = 1'b0;
    endcase
  end

  assign bus.o_led = {page, (state == LAP), led0};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: each step drives the buttons/time,
// queues the outputs expected after the next clock edge and checks them.
module tb_stopwatch_ctrl;

  localparam int BLINK_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.BLINK_DIV(BLINK_DIV)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (sw)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic        clear;
    logic [15:0] data;
    logic [2:0]  led;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t  e;
    string tg;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      tg = sb_tag.pop_front();
      check_val({tg, ".run"},   32'(sw.o_run),   32'(e.run));
      check_val({tg, ".clear"}, 32'(sw.o_clear), 32'(e.clear));
      check_val({tg, ".data"},  32'(sw.o_data),  32'(e.data));
      check_val({tg, ".led"},   32'(sw.o_led),   32'(e.led));
    end
  endtask

  task automatic step(input string tag, input logic st, input logic sel, input logic pg,
                      input logic [23:0] t, input logic run, input logic clear,
                      input logic [15:0] data, input logic [2:0] led);
    exp_t e;
    sw.i_start  = st;
    sw.i_select = sel;
    sw.i_page   = pg;
    sw.i_time   = t;
    e = '{run: run, clear: clear, data: data, led: led};
    sb.push_back(e);
    sb_tag.push_back(tag);
    tick();
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, ".run"},   32'(sw.o_run),   32'd0);
    check_val({tag, ".clear"}, 32'(sw.o_clear), 32'd0);
    check_val({tag, ".data"},  32'(sw.o_data),  32'd0);
    check_val({tag, ".led"},   32'(sw.o_led),   32'd0);
    check_val({tag, ".lap"},   32'(dut.lap_reg), 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    sw.i_start  = 1'b1;
    sw.i_select = 1'b0;
    sw.i_page   = 1'b0;
    sw.i_time   = 24'h000000;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Start held through reset must not fire; a fresh press must
    step("held_rel",   1, 0, 0, 24'h000111, 0, 0, 16'h0111, 3'b000);
    step("held",       1, 0, 0, 24'h000111, 0, 0, 16'h0111, 3'b000);
    step("released",   0, 0, 0, 24'h000111, 0, 0, 16'h0111, 3'b000);
    step("start",      1, 0, 0, 24'h000111, 1, 0, 16'h0111, 3'b001);
    step("start_hold", 1, 0, 0, 24'h000111, 1, 0, 16'h0111, 3'b001);

    // Lap capture and frozen display
    step("run_live",   0, 0, 0, 24'h012345, 1, 0, 16'h2345, 3'b001);
    step("lap",        0, 1, 0, 24'h012345, 1, 0, 16'h2345, 3'b011);
    check_val("lap_capture", 32'(dut.lap_reg), 32'h012345);
    step("lap_frozen", 0, 0, 0, 24'h012399, 1, 0, 16'h2345, 3'b011);
    step("lap_frozen2",0, 0, 0, 24'h012399, 1, 0, 16'h2345, 3'b011);

    // Page toggles while in LAP
    step("page1",      0, 0, 1, 24'h012399, 1, 0, 16'h2345, 3'b111);
    step("page1_data", 0, 0, 0, 24'h012399, 1, 0, 16'h0123, 3'b111);
    step("page0",      0, 0, 1, 24'h012399, 1, 0, 16'h0123, 3'b011);
    step("page0_data", 0, 0, 0, 24'h012399, 1, 0, 16'h2345, 3'b011);

    step("unlap",      0, 1, 0, 24'h012399, 1, 0, 16'h2345, 3'b001);
    step("live",       0, 0, 0, 24'h012399, 1, 0, 16'h2399, 3'b001);
    step("live2",      0, 0, 0, 24'h012400, 1, 0, 16'h2400, 3'b001);

    // Simultaneous start+select: start wins
    step("both",       1, 1, 0, 24'h012400, 0, 0, 16'h2400, 3'b001);
    check_val("both_lap_kept", 32'(dut.lap_reg), 32'h012345);
    step("both_rel",   0, 0, 0, 24'h012400, 0, 0, 16'h2400, 3'b001);
    step("resume",     1, 0, 0, 24'h012400, 1, 0, 16'h2400, 3'b001);
    step("resume_rel", 0, 0, 0, 24'h012400, 1, 0, 16'h2400, 3'b001);

    // Pause blink pattern, then clear back to IDLE
    step("pause",      1, 0, 0, 24'h012400, 0, 0, 16'h2400, 3'b001);
    pat = 8'b1110_0001;
    for (int i = 0; i < 8; i++)
      step($sformatf("blink%0d", i), 0, 0, 0, 24'h012400, 0, 0, 16'h2400, {2'b00, pat[7-i]});
    step("clear",      0, 1, 0, 24'h012400, 0, 1, 16'h2400, 3'b000);
    check_val("clear_lap", 32'(dut.lap_reg), 32'h000000);
    step("clear_end",  0, 0, 0, 24'h012400, 0, 0, 16'h2400, 3'b000);
    step("idle",       0, 0, 0, 24'h012400, 0, 0, 16'h2400, 3'b000);

    // Asynchronous reset in the middle of LAP
    step("run2",       1, 0, 0, 24'h024680, 1, 0, 16'h4680, 3'b001);
    step("run2_rel",   0, 0, 0, 24'h024680, 1, 0, 16'h4680, 3'b001);
    step("lap2",       0, 1, 0, 24'h024680, 1, 0, 16'h4680, 3'b011);
    step("lap2_hold",  0, 0, 0, 24'h099999, 1, 0, 16'h4680, 3'b011);
    #3 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst",   0, 0, 0, 24'h099999, 0, 0, 16'h9999, 3'b000);
    step("post_rst2",  0, 0, 0, 24'h099999, 0, 0, 16'h9999, 3'b000);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
